// File: rtl/pattern_frame_sequencer.sv
// Frame timing and pattern-table sequencer: emits f_sync/sync per line and
// presents one table entry (Mode/constVal/X/Y) for the duration of each frame.
module pattern_frame_sequencer #(
    parameter int NUM_ENTRIES = 4,
    parameter int LINES       = 25,
    parameter int H_BLANK     = 8,
    parameter int V_BLANK     = 16,
    parameter int LEN_REGULAR = 4096,
    parameter int LEN_OTHER   = 1290
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           loop,
    input  logic [$clog2(NUM_ENTRIES):0]   cfg_len,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr,
    input  logic [18:0]                    cfg_wdata,
    output logic                           f_sync,
    output logic                           sync,
    output logic [2:0]                     Mode,
    output logic [11:0]                    constVal,
    output logic [1:0]                     X,
    output logic [1:0]                     Y,
    output logic [$clog2(NUM_ENTRIES)-1:0] entry_idx,
    output logic [4:0]                     line_idx,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int AW    = $clog2(NUM_ENTRIES);
    localparam int LW    = AW + 1;
    localparam int P_REG = LEN_REGULAR + 2 + H_BLANK;
    localparam int P_OTH = LEN_OTHER + 2 + H_BLANK;
    localparam int P_MAX = (P_REG > P_OTH) ? P_REG : P_OTH;
    localparam int T_MAX = (P_MAX > V_BLANK) ? P_MAX : V_BLANK;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LAST_REG  = TW'(P_REG - 2);
    localparam logic [TW-1:0] LAST_OTH  = TW'(P_OTH - 2);
    localparam logic [TW-1:0] VB_LAST   = TW'(V_BLANK - 1);
    localparam logic [4:0]    LAST_LINE = 5'(LINES - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(NUM_ENTRIES);

    typedef enum logic [2:0] {IDLE, LATCH, SYNC, LINE, VBLANK} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] skip_q, skip_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    line_q, line_d;
    logic [2:0]    mode_q, mode_d;
    logic [11:0]   const_q, const_d;
    logic [1:0]    x_q, x_d;
    logic [1:0]    y_q, y_d;
    logic [AW-1:0] entry_q, entry_d;
    logic          frame_done_q, frame_done_d;

    logic [18:0]   tbl_q [NUM_ENTRIES];
    logic [18:0]   entry;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] ptr_inc;
    logic [LW-1:0] skip_inc;
    logic          has_next;
    logic          entry_empty;
    logic [TW-1:0] line_last;
    logic          line_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
        end else if (cfg_we) begin
            tbl_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign entry       = tbl_q[ptr_q];
    assign entry_empty = (entry[18:16] == 3'b000);
    assign len_eff     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign ptr_inc     = {1'b0, ptr_q} + LW'(1);
    assign skip_inc    = skip_q + LW'(1);
    assign has_next    = (ptr_inc < len_eff);
    assign line_last   = (mode_q == 3'b001) ? LAST_REG : LAST_OTH;
    assign line_end    = (timer_q == line_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            skip_q       <= '0;
            timer_q      <= '0;
            line_q       <= '0;
            mode_q       <= '0;
            const_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            entry_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            skip_q       <= skip_d;
            timer_q      <= timer_d;
            line_q       <= line_d;
            mode_q       <= mode_d;
            const_q      <= const_d;
            x_q          <= x_d;
            y_q          <= y_d;
            entry_q      <= entry_d;
            frame_done_q <= frame_done_d;
        end
    end

    // skip_q counts consecutive empty entries so an all-empty table cannot spin forever
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        skip_d  = skip_q;
        timer_d = timer_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                if (enable && (len_eff != '0)) begin
                    state_d = LATCH;
                    ptr_d   = '0;
                    skip_d  = '0;
                end
            end
            LATCH: begin
                if (entry_empty) begin
                    skip_d = skip_inc;
                    if (skip_inc >= len_eff) begin
                        state_d = IDLE;
                    end else if (has_next) begin
                        ptr_d = ptr_q + AW'(1);
                    end else if (loop) begin
                        ptr_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = SYNC;
                    skip_d  = '0;
                    line_d  = '0;
                    timer_d = '0;
                end
            end
            SYNC: begin
                state_d = LINE;
                timer_d = '0;
            end
            LINE: begin
                if (line_end) begin
                    timer_d = '0;
                    if (line_q == LAST_LINE) begin
                        state_d = VBLANK;
                    end else begin
                        line_d  = line_q + 5'd1;
                        state_d = SYNC;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            VBLANK: begin
                if (timer_q == VB_LAST) begin
                    timer_d = '0;
                    skip_d  = '0;
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (has_next) begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = LATCH;
                    end else if (loop) begin
                        ptr_d   = '0;
                        state_d = LATCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d       = mode_q;
        const_d      = const_q;
        x_d          = x_q;
        y_d          = y_q;
        entry_d      = entry_q;
        frame_done_d = (state_q == LINE) && line_end && (line_q == LAST_LINE);
        if ((state_q == LATCH) && !entry_empty) begin
            mode_d  = entry[18:16];
            x_d     = entry[15:14];
            y_d     = entry[13:12];
            const_d = entry[11:0];
            entry_d = ptr_q;
        end
        sync   = (state_q == SYNC);
        f_sync = (state_q == SYNC) && (line_q == 5'd0);
        busy   = (state_q != IDLE);
    end

    assign Mode       = mode_q;
    assign constVal   = const_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign entry_idx  = entry_q;
    assign line_idx   = line_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pattern_frame_sequencer.sv
// Directed bench for pattern_frame_sequencer using shortened line lengths
// (line period 30 for most modes, 50 for the regular mode).
module tb_pattern_frame_sequencer;

    localparam int NE    = 4;
    localparam int AW    = 2;
    localparam int LW    = 3;
    localparam int NL    = 25;
    localparam int VB    = 16;
    localparam int P_REG = 40 + 2 + 8;
    localparam int P_OTH = 20 + 2 + 8;

    localparam logic [2:0] M_REG   = 3'b001;
    localparam logic [2:0] M_WHITE = 3'b010;
    localparam logic [2:0] M_RAMP  = 3'b011;
    localparam logic [2:0] M_CONST = 3'b100;
    localparam logic [2:0] M_BLACK = 3'b101;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          loop;
    logic [LW-1:0] cfg_len;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [18:0]   cfg_wdata;
    logic          f_sync;
    logic          sync;
    logic [2:0]    Mode;
    logic [11:0]   constVal;
    logic [1:0]    X;
    logic [1:0]    Y;
    logic [AW-1:0] entry_idx;
    logic [4:0]    line_idx;
    logic          frame_done;
    logic          busy;

    int checks     = 0;
    int failures   = 0;
    int sync_count = 0;
    int fd_count   = 0;

    pattern_frame_sequencer #(
        .NUM_ENTRIES(NE),
        .LINES      (NL),
        .H_BLANK    (8),
        .V_BLANK    (VB),
        .LEN_REGULAR(40),
        .LEN_OTHER  (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .loop      (loop),
        .cfg_len   (cfg_len),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .f_sync    (f_sync),
        .sync      (sync),
        .Mode      (Mode),
        .constVal  (constVal),
        .X         (X),
        .Y         (Y),
        .entry_idx (entry_idx),
        .line_idx  (line_idx),
        .frame_done(frame_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sample the previous cycle's value at each rising edge
    always @(posedge clk) begin
        if (sync) sync_count <= sync_count + 1;
        if (frame_done) fd_count <= fd_count + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [18:0] data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // sel: 0 = sync, 1 = frame_done, 2 = not busy; n = negedges until the event
    task automatic waitEvent(input int sel, input int limit, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = sync;
                1:       hit = frame_done;
                default: hit = !busy;
            endcase
        end
        if (!hit) begin
            checks++;
            failures++;
            $error("[TB] FAIL timeout sel=%0d: observed no event, required one within %0d cycles", sel, limit);
        end
    endtask

    task automatic runFrame(input string tag, input int gap, input logic [AW-1:0] e_idx,
                            input logic [2:0] e_mode, input logic [11:0] e_const,
                            input logic [1:0] e_x, input logic [1:0] e_y, input int p,
                            input logic drop_enable);
        int n;
        waitEvent(0, 200, n);
        checkOutput({tag, " gap"}, n, gap);
        checkOutput({tag, " f_sync"}, f_sync, 1);
        checkOutput({tag, " entry_idx"}, entry_idx, e_idx);
        checkOutput({tag, " Mode"}, Mode, e_mode);
        checkOutput({tag, " constVal"}, constVal, e_const);
        checkOutput({tag, " X"}, X, e_x);
        checkOutput({tag, " Y"}, Y, e_y);
        if (drop_enable) enable = 1'b0;
        waitEvent(1, 2000, n);
        checkOutput({tag, " length"}, n, NL * p);
        checkOutput({tag, " X end"}, X, e_x);
        checkOutput({tag, " Y end"}, Y, e_y);
    endtask

    initial begin
        int n;
        int sync_base;
        int fd_base;
        rst_n     = 1'b0;
        enable    = 1'b0;
        loop      = 1'b0;
        cfg_len   = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset sync", sync, 0);
        checkOutput("reset f_sync", f_sync, 0);
        checkOutput("reset Mode", Mode, 0);
        checkOutput("reset constVal", constVal, 0);
        checkOutput("reset X", X, 0);
        checkOutput("reset Y", Y, 0);
        checkOutput("reset entry_idx", entry_idx, 0);
        checkOutput("reset line_idx", line_idx, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single constant frame, loop off");
        applyStimulus(0, {M_CONST, 2'b00, 2'b00, 12'hABC});
        cfg_len = 3'd1;
        loop    = 1'b0;
        fd_base = fd_count;
        enable  = 1'b1;
        waitEvent(0, 20, n);
        checkOutput("t1 start latency", n, 2);
        checkOutput("t1 f_sync first", f_sync, 1);
        checkOutput("t1 constVal", constVal, 12'hABC);
        checkOutput("t1 Mode", Mode, M_CONST);
        checkOutput("t1 line_idx0", line_idx, 0);
        checkOutput("t1 busy", busy, 1);
        for (int i = 1; i < NL; i++) begin
            waitEvent(0, 100, n);
            checkOutput("t1 sync spacing", n, P_OTH);
            checkOutput("t1 f_sync later", f_sync, 0);
            checkOutput("t1 line_idx", line_idx, i);
            checkOutput("t1 constVal hold", constVal, 12'hABC);
        end
        waitEvent(1, 100, n);
        checkOutput("t1 frame_done delay", n, P_OTH);
        waitEvent(2, 100, n);
        checkOutput("t1 vblank length", n, VB);
        enable = 1'b0;
        checkOutput("t1 constVal idle", constVal, 12'hABC);
        repeat (2) @(negedge clk);
        checkOutput("t1 frame_done count", fd_count - fd_base, 1);
        checkOutput("t1 busy idle", busy, 0);

        $display("[TB] regular mode line period");
        applyStimulus(0, {M_REG, 2'b01, 2'b10, 12'h123});
        enable = 1'b1;
        waitEvent(0, 20, n);
        checkOutput("t2 start latency", n, 2);
        checkOutput("t2 Mode", Mode, M_REG);
        checkOutput("t2 X", X, 1);
        checkOutput("t2 Y", Y, 2);
        for (int i = 1; i < NL; i++) begin
            waitEvent(0, 200, n);
            checkOutput("t2 sync spacing", n, P_REG);
            checkOutput("t2 line_idx", line_idx, i);
        end
        waitEvent(1, 200, n);
        checkOutput("t2 frame_done delay", n, P_REG);
        waitEvent(2, 100, n);
        checkOutput("t2 vblank length", n, VB);
        enable = 1'b0;

        $display("[TB] three-entry loop");
        applyStimulus(0, {M_WHITE, 2'b00, 2'b00, 12'h111});
        applyStimulus(1, {M_RAMP,  2'b10, 2'b11, 12'h222});
        applyStimulus(2, {M_BLACK, 2'b00, 2'b00, 12'h333});
        cfg_len = 3'd3;
        loop    = 1'b1;
        enable  = 1'b1;
        runFrame("t3 f0", 2,  0, M_WHITE, 12'h111, 2'd0, 2'd0, P_OTH, 1'b0);
        runFrame("t3 f1", 17, 1, M_RAMP,  12'h222, 2'd2, 2'd3, P_OTH, 1'b0);
        runFrame("t3 f2", 17, 2, M_BLACK, 12'h333, 2'd0, 2'd0, P_OTH, 1'b0);
        runFrame("t3 f3", 17, 0, M_WHITE, 12'h111, 2'd0, 2'd0, P_OTH, 1'b1);
        waitEvent(2, 100, n);
        checkOutput("t3 stop vblank", n, VB);

        $display("[TB] empty entry skipping");
        applyStimulus(1, 19'd0);
        enable = 1'b1;
        runFrame("t4 f0", 2,  0, M_WHITE, 12'h111, 2'd0, 2'd0, P_OTH, 1'b0);
        runFrame("t4 f1", 18, 2, M_BLACK, 12'h333, 2'd0, 2'd0, P_OTH, 1'b0);
        runFrame("t4 f2", 17, 0, M_WHITE, 12'h111, 2'd0, 2'd0, P_OTH, 1'b1);
        waitEvent(2, 100, n);
        checkOutput("t4 stop vblank", n, VB);
        applyStimulus(0, 19'd0);
        applyStimulus(2, 19'd0);
        sync_base = sync_count;
        enable = 1'b1;
        @(negedge clk);
        checkOutput("t4 zero latch p0", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("t4 zero latch p1", busy, 1);
        @(negedge clk);
        checkOutput("t4 zero latch p2", busy, 1);
        @(negedge clk);
        checkOutput("t4 zero pass idle", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("t4 zero no sync", sync_count - sync_base, 0);

        $display("[TB] graceful stop and zero length");
        applyStimulus(0, {M_CONST, 2'b00, 2'b00, 12'h555});
        cfg_len = 3'd1;
        loop    = 1'b1;
        enable  = 1'b1;
        waitEvent(0, 20, n);
        checkOutput("t5 start latency", n, 2);
        for (int i = 1; i <= 10; i++) begin
            waitEvent(0, 100, n);
            checkOutput("t5 sync spacing", n, P_OTH);
        end
        checkOutput("t5 line_idx at drop", line_idx, 10);
        enable    = 1'b0;
        sync_base = sync_count;
        fd_base   = fd_count;
        waitEvent(1, 1000, n);
        checkOutput("t5 remaining lines time", n, 15 * P_OTH);
        checkOutput("t5 remaining sync count", sync_count - sync_base, 15);
        waitEvent(2, 100, n);
        checkOutput("t5 vblank length", n, VB);
        repeat (3) @(negedge clk);
        checkOutput("t5 stays idle", busy, 0);
        checkOutput("t5 frame_done count", fd_count - fd_base, 1);
        cfg_len   = 3'd0;
        enable    = 1'b1;
        sync_base = sync_count;
        repeat (5) @(negedge clk);
        checkOutput("t5 len0 busy", busy, 0);
        checkOutput("t5 len0 no sync", sync_count - sync_base, 0);
        enable = 1'b0;

        $display("[TB] mid-frame table write and async reset");
        cfg_len = 3'd1;
        loop    = 1'b1;
        applyStimulus(0, {M_CONST, 2'b01, 2'b10, 12'h777});
        enable = 1'b1;
        waitEvent(0, 20, n);
        checkOutput("t6 start latency", n, 2);
        repeat (3) waitEvent(0, 100, n);
        applyStimulus(0, {M_WHITE, 2'b11, 2'b11, 12'h999});
        checkOutput("t6 constVal after write", constVal, 12'h777);
        checkOutput("t6 Mode after write", Mode, M_CONST);
        checkOutput("t6 X after write", X, 1);
        checkOutput("t6 Y after write", Y, 2);
        waitEvent(1, 1000, n);
        checkOutput("t6 constVal frame end", constVal, 12'h777);
        waitEvent(0, 100, n);
        checkOutput("t6 next frame gap", n, 17);
        checkOutput("t6 new constVal", constVal, 12'h999);
        checkOutput("t6 new Mode", Mode, M_WHITE);
        checkOutput("t6 new X", X, 3);
        checkOutput("t6 new Y", Y, 3);
        waitEvent(0, 100, n);
        checkOutput("t6 line1 spacing", n, P_OTH);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst sync", sync, 0);
        checkOutput("t6 rst f_sync", f_sync, 0);
        checkOutput("t6 rst Mode", Mode, 0);
        checkOutput("t6 rst constVal", constVal, 0);
        checkOutput("t6 rst X", X, 0);
        checkOutput("t6 rst Y", Y, 0);
        checkOutput("t6 rst line_idx", line_idx, 0);
        checkOutput("t6 rst entry_idx", entry_idx, 0);
        checkOutput("t6 rst busy", busy, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        sync_base = sync_count;
        repeat (20) @(negedge clk);
        checkOutput("t6 cleared table no sync", sync_count - sync_base, 0);
        checkOutput("t6 cleared table constVal", constVal, 0);
        enable = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
